// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single-port SRAM.
// D-port has priority; a saturating starvation counter forces an I grant.
module mem_arbiter #(
  parameter int AWIDTH     = 12,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [AWIDTH-1:0] i_req_addr,
  output logic              i_rsp_valid,
  output logic [31:0]       i_rsp_rdata,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_req_we,
  input  logic [3:0]        d_req_be,
  input  logic [AWIDTH-1:0] d_req_addr,
  input  logic [31:0]       d_req_wdata,
  output logic              d_rsp_valid,
  output logic [31:0]       d_rsp_rdata,
  output logic              CSN,
  output logic              WEN,
  output logic [3:0]        BE,
  output logic [AWIDTH-1:0] ADDR,
  output logic [31:0]       DI,
  input  logic [31:0]       DOUT
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t     state;
  logic [2:0] starve_cnt;
  logic       r_port;
  logic       r_we;
  logic       starved;
  logic       grant_d;
  logic       open;

  assign starved = starve_cnt >= 3'(STARVE_MAX);
  assign grant_d = d_req_valid && !(i_req_valid && starved);
  assign open    = (state != ACCESS) && !RST;

  assign d_req_ready = grant_d && open;
  assign i_req_ready = i_req_valid && !grant_d && open;

  // SRAM pins are registered straight from the accepted request,
  // so they are live exactly during the ACCESS cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      starve_cnt  <= 3'd0;
      r_port      <= 1'b0;
      r_we        <= 1'b0;
      CSN         <= 1'b1;
      WEN         <= 1'b1;
      BE          <= 4'h0;
      ADDR        <= '0;
      DI          <= 32'h0;
      i_rsp_valid <= 1'b0;
      d_rsp_valid <= 1'b0;
      i_rsp_rdata <= 32'h0;
      d_rsp_rdata <= 32'h0;
    end else begin
      i_rsp_valid <= 1'b0;
      d_rsp_valid <= 1'b0;
      CSN         <= 1'b1;
      WEN         <= 1'b1;
      BE          <= 4'h0;
      ADDR        <= '0;
      DI          <= 32'h0;
      unique case (state)
        ACCESS: begin
          state <= RESP;
          if (r_port) begin
            d_rsp_valid <= 1'b1;
            d_rsp_rdata <= r_we ? 32'h0 : DOUT;
          end else begin
            i_rsp_valid <= 1'b1;
            i_rsp_rdata <= DOUT;
          end
        end
        default: begin
          state <= (i_req_ready || d_req_ready) ? ACCESS : IDLE;
        end
      endcase
      if (d_req_ready) begin
        r_port <= 1'b1;
        r_we   <= d_req_we;
        CSN    <= 1'b0;
        WEN    <= !d_req_we;
        BE     <= d_req_be;
        ADDR   <= d_req_addr;
        DI     <= d_req_wdata;
        if (i_req_valid && starve_cnt != 3'd7)
          starve_cnt <= starve_cnt + 3'd1;
      end else if (i_req_ready) begin
        r_port     <= 1'b0;
        r_we       <= 1'b0;
        CSN        <= 1'b0;
        WEN        <= 1'b1;
        BE         <= 4'hF;
        ADDR       <= i_req_addr;
        DI         <= 32'h0;
        starve_cnt <= 3'd0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural byte-write SRAM.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_mem_arbiter;

  localparam int AW = 12;

  logic          CLK;
  logic          RST;
  logic          i_req_valid;
  logic          i_req_ready;
  logic [AW-1:0] i_req_addr;
  logic          i_rsp_valid;
  logic [31:0]   i_rsp_rdata;
  logic          d_req_valid;
  logic          d_req_ready;
  logic          d_req_we;
  logic [3:0]    d_req_be;
  logic [AW-1:0] d_req_addr;
  logic [31:0]   d_req_wdata;
  logic          d_rsp_valid;
  logic [31:0]   d_rsp_rdata;
  logic          CSN;
  logic          WEN;
  logic [3:0]    BE;
  logic [AW-1:0] ADDR;
  logic [31:0]   DI;
  logic [31:0]   DOUT;

  logic [31:0] mem [0:(1<<AW)-1];

  int n_tests;
  int n_fail;
  int ng;
  int ni;
  int nd;
  logic [7:0] rdy;
  logic [7:0] csl;
  logic [7:0] rsv;
  logic [9:0] grants;

  mem_arbiter #(.AWIDTH(AW), .STARVE_MAX(4)) dut (
    .CLK(CLK),
    .RST(RST),
    .i_req_valid(i_req_valid),
    .i_req_ready(i_req_ready),
    .i_req_addr(i_req_addr),
    .i_rsp_valid(i_rsp_valid),
    .i_rsp_rdata(i_rsp_rdata),
    .d_req_valid(d_req_valid),
    .d_req_ready(d_req_ready),
    .d_req_we(d_req_we),
    .d_req_be(d_req_be),
    .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid),
    .d_rsp_rdata(d_rsp_rdata),
    .CSN(CSN),
    .WEN(WEN),
    .BE(BE),
    .ADDR(ADDR),
    .DI(DI),
    .DOUT(DOUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign DOUT = mem[ADDR];

  always @(negedge CLK) begin
    if (!CSN && !WEN) begin
      for (int b = 0; b < 4; b++)
        if (BE[b]) mem[ADDR][8*b +: 8] <= DI[8*b +: 8];
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic d_write(input logic [AW-1:0] a,
                         input logic [3:0] be,
                         input logic [31:0] wd);
    d_req_valid = 1'b1;
    d_req_we    = 1'b1;
    d_req_be    = be;
    d_req_addr  = a;
    d_req_wdata = wd;
    step();
    d_req_valid = 1'b0;
    step();
    step();
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    RST         = 1'b1;
    i_req_valid = 1'b1;
    i_req_addr  = '0;
    d_req_valid = 1'b0;
    d_req_we    = 1'b0;
    d_req_be    = 4'h0;
    d_req_addr  = '0;
    d_req_wdata = 32'h0;
    repeat (2) @(posedge CLK);
    #1;
    @(negedge CLK);
    check("rst_i_ready", 32'(i_req_ready), 32'd0);
    check("rst_csn", 32'(CSN), 32'd1);
    check("rst_wen", 32'(WEN), 32'd1);
    check("rst_be", 32'(BE), 32'd0);
    check("rst_addr", 32'(ADDR), 32'd0);
    check("rst_i_rsp", 32'(i_rsp_valid), 32'd0);
    check("rst_d_rsp", 32'(d_rsp_valid), 32'd0);
    step();
    RST         = 1'b0;
    i_req_valid = 1'b0;
    step();

    d_write(12'h010, 4'hF, 32'hDEADBEEF);
    d_write(12'h020, 4'hF, 32'hAABBCCDD);

    // single I-read
    i_req_valid = 1'b1;
    i_req_addr  = 12'h010;
    @(negedge CLK);
    check("iread_ready", 32'(i_req_ready), 32'd1);
    step();
    i_req_valid = 1'b0;
    @(negedge CLK);
    check("iread_csn", 32'(CSN), 32'd0);
    check("iread_wen", 32'(WEN), 32'd1);
    check("iread_addr", 32'(ADDR), 32'h010);
    step();
    @(negedge CLK);
    check("iread_rsp", 32'(i_rsp_valid), 32'd1);
    check("iread_data", i_rsp_rdata, 32'hDEADBEEF);
    check("iread_drsp", 32'(d_rsp_valid), 32'd0);
    step();
    @(negedge CLK);
    check("iread_rsp_end", 32'(i_rsp_valid), 32'd0);
    check("iread_hold", i_rsp_rdata, 32'hDEADBEEF);
    step();

    // byte write then read back
    d_req_valid = 1'b1;
    d_req_we    = 1'b1;
    d_req_be    = 4'b0011;
    d_req_addr  = 12'h020;
    d_req_wdata = 32'h12345678;
    @(negedge CLK);
    check("bw_ready", 32'(d_req_ready), 32'd1);
    step();
    d_req_valid = 1'b0;
    @(negedge CLK);
    check("bw_wen", 32'(WEN), 32'd0);
    check("bw_be", 32'(BE), 32'h3);
    check("bw_di", DI, 32'h12345678);
    step();
    @(negedge CLK);
    check("bw_rsp", 32'(d_rsp_valid), 32'd1);
    check("bw_rdata", d_rsp_rdata, 32'h0);
    step();
    d_req_valid = 1'b1;
    d_req_we    = 1'b0;
    step();
    d_req_valid = 1'b0;
    step();
    @(negedge CLK);
    check("rb_rsp", 32'(d_rsp_valid), 32'd1);
    check("rb_data", d_rsp_rdata, 32'hAABB5678);
    step();

    // back-to-back D reads
    rdy = '0;
    csl = '0;
    rsv = '0;
    d_req_addr = 12'h010;
    for (int c = 1; c <= 7; c++) begin
      d_req_valid = (c <= 6);
      @(negedge CLK);
      rdy[c] = d_req_ready;
      csl[c] = !CSN;
      rsv[c] = d_rsp_valid;
      step();
    end
    d_req_valid = 1'b0;
    check("b2b_grant", 32'(rdy), 32'h2A);
    check("b2b_csn", 32'(csl), 32'h54);
    check("b2b_rsp", 32'(rsv), 32'hA8);
    check("b2b_data", d_rsp_rdata, 32'hDEADBEEF);

    // contention with starvation relief
    ng = 0;
    ni = 0;
    nd = 0;
    grants = '0;
    i_req_valid = 1'b1;
    i_req_addr  = 12'h010;
    d_req_valid = 1'b1;
    d_req_we    = 1'b0;
    d_req_addr  = 12'h020;
    for (int cyc = 0; cyc < 60 && ng < 10; cyc++) begin
      @(negedge CLK);
      if (d_req_ready) begin
        grants[ng] = 1'b1;
        ng++;
      end else if (i_req_ready) begin
        grants[ng] = 1'b0;
        ng++;
      end
      if (i_rsp_valid) ni++;
      if (d_rsp_valid) nd++;
      step();
      if (ng == 10) begin
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
      end
    end
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      if (i_rsp_valid) ni++;
      if (d_rsp_valid) nd++;
      step();
    end
    check("cont_ngrants", 32'(ng), 32'd10);
    check("cont_order", 32'(grants), 32'h1EF);
    check("cont_i_rsp", 32'(ni), 32'd2);
    check("cont_d_rsp", 32'(nd), 32'd8);
    check("cont_i_data", i_rsp_rdata, 32'hDEADBEEF);
    check("cont_d_data", d_rsp_rdata, 32'hAABB5678);

    // reset during ACCESS of an I-read
    i_req_valid = 1'b1;
    i_req_addr  = 12'h020;
    step();
    i_req_valid = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    check("mrst_access", 32'(CSN), 32'd0);
    step();
    RST = 1'b0;
    @(negedge CLK);
    check("mrst_csn", 32'(CSN), 32'd1);
    check("mrst_rsp", 32'(i_rsp_valid), 32'd0);
    step();
    i_req_valid = 1'b1;
    @(negedge CLK);
    check("mrst_rsp2", 32'(i_rsp_valid), 32'd0);
    check("mrst_idle", 32'(i_req_ready), 32'd1);
    step();
    i_req_valid = 1'b0;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AWIDTH, default 12: SRAM word-address width.
REQ-002 Parameter STARVE_MAX, default 4: consecutive lost arbitrations after which the I-port is forced to win.
REQ-003 CLK  input  1  single clock; all state updates on posedge. Reset is synchronous and active-high.
REQ-004 RST  input  1  synchronous, active-high reset, sampled on posedge CLK.
REQ-005 i_req_valid  input  1  instruction-fetch (I-port) read request.
REQ-006 i_req_ready  output  1  I-port request accepted this cycle.
REQ-007 i_req_addr  input  AWIDTH  I-port word address.
REQ-008 i_rsp_valid  output  1  one-cycle pulse: I-port read data valid.
REQ-009 i_rsp_rdata  output  32  I-port read data.
REQ-010 d_req_valid  input  1  data-port (D-port) request.
REQ-011 d_req_ready  output  1  D-port request accepted this cycle.
REQ-012 d_req_we  input  1  D-port write (1) or read (0).
REQ-013 d_req_be  input  4  D-port byte enables for writes.
REQ-014 d_req_addr  input  AWIDTH  D-port word address.
REQ-015 d_req_wdata  input  32  D-port write data.
REQ-016 d_rsp_valid  output  1  one-cycle pulse: D-port access complete.
REQ-017 d_rsp_rdata  output  32  D-port read data; 0 for writes.
REQ-018 CSN, WEN  output  1 each  SRAM chip select and write enable, both active-low.
REQ-019 BE  output  4  SRAM byte enables.
REQ-020 ADDR  output  AWIDTH  SRAM word address.
REQ-021 DI  output  32  SRAM write data.
REQ-022 DOUT  input  32  SRAM asynchronous read data.

Function
REQ-023 FSM states: IDLE, ACCESS, RESP. Transitions: IDLE->ACCESS on handshake; ACCESS->RESP unconditionally; RESP->ACCESS on handshake, else RESP->IDLE.
REQ-024 Handshakes are accepted only in IDLE or RESP, at most one per cycle; x_req_ready is combinational and equals x_req_valid AND grant-to-x AND state is not ACCESS.
REQ-025 Grant rule: the D-port wins when both ports are valid. Exception: if starve_cnt >= STARVE_MAX, the I-port wins.
REQ-026 starve_cnt (3 bits, saturating):
  - increments when I-port is valid and D-port is granted;
  - clears on any I-port grant;
  - is unchanged otherwise.
REQ-027 On handshake, the port id, we, be, addr and wdata are registered. An I-port request is latched as we=0, be=4'hF.
REQ-028 ACCESS drives the SRAM from the registered request:
  - CSN=0, ADDR=addr, BE=be, DI=wdata;
  - WEN=0 only for writes.
REQ-029 Outside ACCESS, the SRAM outputs are CSN=1, WEN=1, BE=0, ADDR=0, DI=0.
REQ-030 At the posedge that ends ACCESS, DOUT is captured into the response register; for writes, 0 is captured instead.
REQ-031 In RESP, exactly the granted port's rsp_valid is 1 for one cycle, with rdata = the captured value. The other port's rsp_valid is 0.
REQ-032 Latency: handshake at cycle N -> SRAM access at cycle N+1 -> rsp_valid at N+2.
REQ-033 Peak throughput is one access per 2 cycles, via back-to-back RESP->ACCESS.
REQ-034 rsp_rdata holds its last value when rsp_valid=0.
REQ-035 A request stays pending while its valid is held. The arbiter never drops or reorders an accepted request.

Reset
REQ-036 Reset state and outputs:
  - state=IDLE, starve_cnt=0, all registers 0;
  - i/d_req_ready=0 during reset cycle, i/d_rsp_valid=0;
  - CSN=1, WEN=1, BE=0, ADDR=0, DI=0.
REQ-037 Reset asserted in ACCESS or RESP aborts the transaction, and no rsp_valid is issued for it. A write whose SRAM negedge has already occurred is not undone.

Verification
REQ-038 Single I-read: mem[0x010]=0xDEADBEEF, I-port valid, addr=0x010 at cycle 1 -> i_req_ready=1 at cycle 1; CSN=0, WEN=1 at cycle 2; i_rsp_valid=1 with rdata=0xDEADBEEF at cycle 3.
REQ-039 Byte write: D-port writes addr 0x020, be=4'b0011, wdata=0x12345678 over mem=0xAABBCCDD -> WEN=0 in ACCESS, d_rsp_valid with rdata=0; a subsequent D-read returns 0xAABB5678.
REQ-040 Contention: both ports valid continuously -> D granted 4 times, then I granted once (starve_cnt reaches 4), and the pattern repeats; no request is lost.
REQ-041 Back-to-back: D-port valid every cycle -> grants at cycles 1, 3, 5; CSN=0 only at cycles 2, 4, 6; rsp_valid at cycles 3, 5, 7.
REQ-042 Reset mid-access: RST=1 during ACCESS of an I-read -> next cycle state IDLE, CSN=1, and no i_rsp_valid.
